// File: rtl/gtx_pkg.sv
// Shared definitions for the GTX link layer (gtx_tx / gtx_rx): K28.5 comma
// and idle constants, the receive lock state, the aligned-word record, and
// small helpers used by the receive path.
package gtx_pkg;

  localparam logic [7:0]  K28_5     = 8'hBC;
  localparam logic [15:0] IDLE_WORD = 16'h50BC;
  localparam logic [1:0]  IDLE_CTRL = 2'b01;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;

  // One 16-bit word with its per-byte K flags and per-byte code errors.
  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  ctrl;
    logic [1:0]  err;
  } rx_word_t;

  // 4-bit increment that sticks at 15 instead of wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // An aligned word is a good comma when only byte 0 is a K char and it is K28.5.
  function automatic logic is_good_comma(input rx_word_t w);
    return (w.ctrl == IDLE_CTRL) && (w.data[7:0] == K28_5);
  endfunction

endpackage

// File: rtl/gtx_rx_align.sv
// gtx_rx_align: stage-1 capture of the raw transceiver word, byte-offset
// mux that rebuilds the aligned word, and raw comma detection on stage 1.
// With offset 1 the aligned word is formed from the high byte of the
// stage-1 word and the low byte of the word currently on the inputs.
module gtx_rx_align
  import gtx_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [15:0] data_i,
  input  logic [1:0]  ctrl_i,
  input  logic [1:0]  codeerr_i,
  input  logic        offset_i,
  output rx_word_t    word_o,
  output logic        pos0_o,
  output logic        pos1_o
);

  logic [15:0] s1_data_q;
  logic [1:0]  s1_ctrl_q;
  logic [1:0]  s1_err_q;

  // Stage-1 capture of the raw RX word.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_data_q <= '0;
      s1_ctrl_q <= '0;
      s1_err_q  <= '0;
    end else begin
      s1_data_q <= data_i;
      s1_ctrl_q <= ctrl_i;
      s1_err_q  <= codeerr_i;
    end
  end

  // Offset mux: offset 1 pairs the stage-1 high byte with the incoming low byte.
  always_comb begin
    // NOTE: every output of this block gets a value on every path, so no
    // latch is inferred.
    word_o = '{data: s1_data_q, ctrl: s1_ctrl_q, err: s1_err_q};
    if (offset_i) begin
      word_o.data = {data_i[7:0], s1_data_q[15:8]};
      word_o.ctrl = {ctrl_i[0], s1_ctrl_q[1]};
      word_o.err  = {codeerr_i[0], s1_err_q[1]};
    end
  end

  // Raw comma position on the stage-1 word; byte 0 wins if both match.
  always_comb begin
    pos0_o = s1_ctrl_q[0] && (s1_data_q[7:0] == K28_5);
    pos1_o = !pos0_o && s1_ctrl_q[1] && (s1_data_q[15:8] == K28_5);
  end

endmodule

// File: rtl/gtx_rx.sv
// gtx_rx: receive link layer for the GTX serial link. Finds the K28.5 comma,
// fixes the 2-byte word misalignment, acquires/monitors lock
// (HUNT -> CHECK -> LOCKED) and presents aligned payload words with a
// valid strobe; comma/idle words are stripped.
// Optional build macro GTX_RX_ERR_CNT_EN adds err_cnt_o, a saturating count
// of error cycles seen while LOCKED.
module gtx_rx
  import gtx_pkg::*;
#(
  parameter int unsigned LOCK_COMMAS = 3,  // 1..15
  parameter int unsigned LOSS_ERRS   = 4   // 1..15
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [15:0] data_i,
  input  logic [1:0]  ctrl_i,
  input  logic [1:0]  codeerr_i,
  output logic [15:0] data_o,
  output logic        valid_o,
  output logic        locked_o,
  output logic        offset_o
`ifdef GTX_RX_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt_o
`endif
);

  // A good comma whose incremented count reaches LOCK_LAST completes the lock;
  // an error whose incremented count reaches LOSS_LAST drops it.
  localparam logic [3:0] LOCK_LAST = 4'(LOCK_COMMAS - 1);
  localparam logic [3:0] LOSS_LAST = 4'(LOSS_ERRS);

  rx_state_t   state_q, state_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic [3:0]  bad_cnt_q, bad_cnt_d;
  logic        offset_q, offset_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        locked_q, locked_d;

  rx_word_t    word;
  logic        pos0;
  logic        pos1;
  logic        good_comma;
  logic        error;
  logic [3:0]  good_inc;
  logic [3:0]  bad_inc;

  gtx_rx_align u_align (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .data_i    (data_i),
    .ctrl_i    (ctrl_i),
    .codeerr_i (codeerr_i),
    .offset_i  (offset_q),
    .word_o    (word),
    .pos0_o    (pos0),
    .pos1_o    (pos1)
  );

  // Classify the aligned word at the current offset.
  always_comb begin
    good_comma = is_good_comma(word);
    error      = (|word.err)
              || (offset_q ? pos0 : pos1)
              || word.ctrl[1];
    good_inc   = sat_inc4(good_cnt_q);
    bad_inc    = sat_inc4(bad_cnt_q);
  end

  // FSM state, lock counters and byte offset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= HUNT;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      offset_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      offset_q   <= offset_d;
    end
  end

  // Next-state logic: acquire on a raw comma, confirm, then monitor for loss.
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    offset_d   = offset_q;
    unique case (state_q)
      HUNT: begin
        if (pos0 || pos1) begin
          offset_d   = pos1;
          good_cnt_d = '0;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        if (error) begin
          state_d = HUNT;
        end else if (good_comma) begin
          good_cnt_d = good_inc;
          if (good_inc >= LOCK_LAST) state_d = LOCKED;
        end
      end
      LOCKED: begin
        // An error outranks a comma arriving in the same cycle.
        if (error) begin
          if (bad_inc >= LOSS_LAST) begin
            bad_cnt_d = '0;
            state_d   = HUNT;
          end else begin
            bad_cnt_d = bad_inc;
          end
        end else if (good_comma) begin
          bad_cnt_d = '0;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // Output decode: only clean data words in LOCKED produce a payload strobe.
  always_comb begin
    valid_d  = (state_q == LOCKED) && (word.ctrl == 2'b00) && !error;
    data_d   = valid_d ? word.data : data_q;
    locked_d = (state_d == LOCKED);
  end

  // Output registers; data_o holds its last payload between strobes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
    end
  end

  assign data_o   = data_q;
  assign valid_o  = valid_q;
  assign locked_o = locked_q;
  assign offset_o = offset_q;

`ifdef GTX_RX_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Saturating count of error cycles seen while LOCKED; only reset clears it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_cnt_q <= '0;
    end else if ((state_q == LOCKED) && error && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_gtx_rx.sv
// Self-checking bench for gtx_rx. Payload words expected at the output are
// pushed to a scoreboard (with the cycle they are due) as they are driven,
// and popped/compared each cycle when valid_o is seen.
module tb_gtx_rx;
  import gtx_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [15:0] data_i = '0;
  logic [1:0]  ctrl_i = '0;
  logic [1:0]  codeerr_i = '0;
  logic [15:0] data_o;
  logic        valid_o;
  logic        locked_o;
  logic        offset_o;
`ifdef GTX_RX_ERR_CNT_EN
  logic [15:0] err_cnt_o;
`endif

  gtx_rx #(.LOCK_COMMAS(3), .LOSS_ERRS(4)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .data_i    (data_i),
    .ctrl_i    (ctrl_i),
    .codeerr_i (codeerr_i),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .locked_o  (locked_o),
    .offset_o  (offset_o)
`ifdef GTX_RX_ERR_CNT_EN
    ,
    .err_cnt_o (err_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   tick = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  // Drive one raw word, optionally expect a payload word two cycles later,
  // then sample outputs #1 after the edge and score any strobe.
  task automatic send(input logic [15:0] d, input logic [1:0] c, input logic [1:0] e,
                      input bit push, input logic [15:0] exp_data);
    exp_t x;
    data_i = d; ctrl_i = c; codeerr_i = e;
    if (push) begin
      x.data = exp_data;
      x.due  = tick + 2;
      sb.push_back(x);
    end
    @(posedge clk_i); #1;
    tick++;
    if (valid_o === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid: data_o=%h at tick %0d, no word expected", data_o, tick);
      end else begin
        x = sb.pop_front();
        if (data_o !== x.data || tick != x.due) begin
          n_err++;
          $display("FAIL payload: got %h at tick %0d, want %h at tick %0d", data_o, tick, x.data, x.due);
        end
      end
    end else if (sb.size() != 0 && sb[0].due <= tick) begin
      n_cmp++;
      n_err++;
      x = sb.pop_front();
      $display("FAIL missing_valid: valid_o=%b at tick %0d, want %h", valid_o, tick, x.data);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(IDLE_WORD, IDLE_CTRL, 2'b00, 1'b0, '0);
  endtask

  task automatic apply_reset();
    rst_n_i = 1'b0;
    data_i = '0; ctrl_i = '0; codeerr_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    sb.delete();
  endtask

  task automatic lock_aligned();
    apply_reset();
    idle(3);
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    #2;
    n_cmp += 4;
    if (data_o !== 16'h0)  begin n_err++; $display("FAIL reset_data: got %h want 0000", data_o); end
    if (valid_o !== 1'b0)  begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    if (locked_o !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %b want 0", locked_o); end
    if (offset_o !== 1'b0) begin n_err++; $display("FAIL reset_offset: got %b want 0", offset_o); end
`ifdef GTX_RX_ERR_CNT_EN
    n_cmp++;
    if (err_cnt_o !== 16'h0) begin n_err++; $display("FAIL reset_err_cnt: got %h want 0000", err_cnt_o); end
`endif
  endtask

  task automatic test_aligned();
    apply_reset();
    idle(3);
    n_cmp++;
    if (locked_o !== 1'b0) begin n_err++; $display("FAIL aligned_early_lock: got %b want 0", locked_o); end
    send(16'hDEAD, 2'b00, 2'b00, 1'b1, 16'hDEAD);
    n_cmp += 2;
    if (locked_o !== 1'b1) begin n_err++; $display("FAIL aligned_locked: got %b want 1", locked_o); end
    if (offset_o !== 1'b0) begin n_err++; $display("FAIL aligned_offset: got %b want 0", offset_o); end
    idle(3);
    n_cmp += 2;
    if (data_o !== 16'hDEAD) begin n_err++; $display("FAIL aligned_hold: got %h want dead", data_o); end
    if (valid_o !== 1'b0)    begin n_err++; $display("FAIL aligned_comma_valid: got %b want 0", valid_o); end
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL aligned_drain: %0d left, want 0", sb.size()); end
  endtask

  task automatic test_misaligned();
    apply_reset();
    for (int i = 0; i < 3; i++) send(16'hBC50, 2'b10, 2'b00, 1'b0, '0);
    send(16'hAD50, 2'b00, 2'b00, 1'b1, 16'hDEAD);
    send(16'hBCDE, 2'b10, 2'b00, 1'b0, '0);
    for (int i = 0; i < 3; i++) send(16'hBC50, 2'b10, 2'b00, 1'b0, '0);
    n_cmp += 3;
    if (offset_o !== 1'b1)   begin n_err++; $display("FAIL mis_offset: got %b want 1", offset_o); end
    if (locked_o !== 1'b1)   begin n_err++; $display("FAIL mis_locked: got %b want 1", locked_o); end
    if (data_o !== 16'hDEAD) begin n_err++; $display("FAIL mis_data: got %h want dead", data_o); end
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL mis_drain: %0d left, want 0", sb.size()); end
  endtask

  task automatic test_loss_of_lock();
    lock_aligned();
    send(16'hDEAD, 2'b00, 2'b00, 1'b1, 16'hDEAD);
    for (int i = 0; i < 4; i++) send(16'h1111, 2'b00, 2'b01, 1'b0, '0);
    n_cmp++;
    if (locked_o !== 1'b1) begin n_err++; $display("FAIL loss_before: got %b want 1", locked_o); end
    send(16'h2222, 2'b00, 2'b00, 1'b0, '0);
    n_cmp++;
    if (locked_o !== 1'b0) begin n_err++; $display("FAIL loss_after: got %b want 0", locked_o); end
    for (int i = 0; i < 4; i++) send(16'h3333, 2'b00, 2'b00, 1'b0, '0);
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL loss_drain: %0d left, want 0", sb.size()); end
  endtask

  task automatic test_error_recovery();
    lock_aligned();
    for (int i = 0; i < 3; i++) send(16'h1111, 2'b00, 2'b01, 1'b0, '0);
    idle(1);
    for (int i = 0; i < 3; i++) send(16'h1111, 2'b00, 2'b10, 1'b0, '0);
    send(16'hBEEF, 2'b00, 2'b00, 1'b1, 16'hBEEF);
    idle(2);
    n_cmp += 2;
    if (locked_o !== 1'b1) begin n_err++; $display("FAIL recover_locked: got %b want 1", locked_o); end
    if (sb.size() != 0)    begin n_err++; $display("FAIL recover_drain: %0d left, want 0", sb.size()); end
  endtask

  task automatic test_check_error();
    apply_reset();
    idle(1);
    send(16'h1234, 2'b00, 2'b01, 1'b0, '0);
    idle(2);
    for (int i = 0; i < 3; i++) send(16'h5678, 2'b00, 2'b00, 1'b0, '0);
    n_cmp++;
    if (locked_o !== 1'b0) begin n_err++; $display("FAIL check_err_locked: got %b want 0", locked_o); end
  endtask

  task automatic test_reset_mid_stream();
    lock_aligned();
    send(16'hDEAD, 2'b00, 2'b00, 1'b1, 16'hDEAD);
    send(16'hDEAD, 2'b00, 2'b00, 1'b1, 16'hDEAD);
    send(16'hDEAD, 2'b00, 2'b00, 1'b0, '0);  // in flight, cut off by reset
    rst_n_i = 1'b0;
    #1;
    n_cmp += 4;
    if (data_o !== 16'h0)  begin n_err++; $display("FAIL mid_rst_data: got %h want 0000", data_o); end
    if (valid_o !== 1'b0)  begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", valid_o); end
    if (locked_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_locked: got %b want 0", locked_o); end
    if (offset_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_offset: got %b want 0", offset_o); end
    send(16'hDEAD, 2'b00, 2'b00, 1'b0, '0);
    rst_n_i = 1'b1;
    send(16'hDEAD, 2'b00, 2'b00, 1'b0, '0);
    idle(3);
    send(16'hCAFE, 2'b00, 2'b00, 1'b1, 16'hCAFE);
    idle(2);
    n_cmp += 2;
    if (locked_o !== 1'b1) begin n_err++; $display("FAIL mid_relock: got %b want 1", locked_o); end
    if (sb.size() != 0)    begin n_err++; $display("FAIL mid_drain: %0d left, want 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    lock_aligned();
    for (int i = 0; i < 24; i++) begin
      if (i % 5 == 4) begin
        idle(1);
      end else begin
        w = 16'($urandom);
        send(w, 2'b00, 2'b00, 1'b1, w);
      end
    end
    idle(3);
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL b2b_drain: %0d left, want 0", sb.size()); end
  endtask

`ifdef GTX_RX_ERR_CNT_EN
  task automatic test_err_cnt();
    lock_aligned();
    for (int i = 0; i < 5; i++) send(16'h1111, 2'b00, 2'b01, 1'b0, '0);
    idle(1);
    n_cmp++;
    if (err_cnt_o !== 16'd4) begin n_err++; $display("FAIL err_cnt: got %0d want 4", err_cnt_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_aligned();
    test_misaligned();
    test_loss_of_lock();
    test_error_recovery();
    test_check_error();
    test_reset_mid_stream();
    test_back_to_back();
`ifdef GTX_RX_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gtx_rx.md
Name: gtx_rx

Overview:
Receive-side link layer for the GTX serial link. It is the counterpart of gtx_tx and sits between the transceiver RX user interface (rxusrclk2 domain, 16-bit data plus 2-bit charisk) and user logic. It finds the K28.5 comma, corrects the 2-byte word misalignment, and acquires and monitors lock. It strips comma/idle words and presents aligned 16-bit payload words with a valid strobe.

Parameters:
LOCK_COMMAS, 3, consecutive correctly placed commas needed to move from CHECK to LOCKED (range 1-15).
LOSS_ERRS, 4, errors in LOCKED, without an intervening good comma, that force a return to HUNT (range 1-15).

Ports:
clk_i  in  1  RX user clock (gt0_rxusrclk2); the only clock.
rst_n_i  in  1  asynchronous, active-low reset.
data_i  in  16  raw RX data (gt0_rxdata); byte 0 is [7:0].
ctrl_i  in  2  raw RX charisk; bit n flags byte n as a K character.
codeerr_i  in  2  per-byte rxdisperr | rxnotintable.
data_o  out  16  aligned payload word.
valid_o  out  1  data_o holds a new payload word this cycle.
locked_o  out  1  FSM is in LOCKED.
offset_o  out  1  current byte offset (0 = comma found in byte 0, 1 = comma found in byte 1).

Behaviour:
- Reset values: data_o=0, valid_o=0, locked_o=0, offset_o=0, FSM in HUNT, all counters 0, stage-1 registers 0.
- Stage 1 registers data_i, ctrl_i and codeerr_i as s1_*.
- Aligned word when offset=0: s1 (data, ctrl, err).
- Aligned word when offset=1: data = {data_i[7:0], s1_data[15:8]}; ctrl = {ctrl_i[0], s1_ctrl[1]}; err takes the same byte mapping.
- Raw comma detection on s1:
  - pos0 when s1_ctrl[0]=1 and s1_data[7:0]=8'hBC.
  - pos1 when s1_ctrl[1]=1 and s1_data[15:8]=8'hBC.
  - If both are set, pos0 wins.
- good comma: the aligned word has ctrl=2'b01 and low byte=8'hBC at the current offset.
- error: any aligned err bit set; or a raw comma at the other offset; or aligned ctrl equal to 2'b10 or 2'b11.
- HUNT:
  - On pos0 or pos1: latch offset (0 or 1), clear good_cnt, go to CHECK.
  - Otherwise stay.
- CHECK:
  - good comma increments good_cnt; when good_cnt reaches LOCK_COMMAS-1 on a good comma, go to LOCKED.
  - error returns to HUNT.
  - Data words (ctrl=00, no error) are neutral.
- LOCKED:
  - good comma clears bad_cnt.
  - error increments bad_cnt; when it reaches LOSS_ERRS, go to HUNT and clear bad_cnt.
  - If error and a comma occur in the same cycle, error takes priority.
- Offset changes only on the HUNT->CHECK transition.
- Output stage:
  - valid_o=1 only when the FSM is LOCKED, the aligned ctrl=00 and there is no error.
  - data_o updates only when valid_o=1 and holds otherwise.
  - Comma words never assert valid_o.
- Latency: 2 clk_i cycles from the input word that carries an aligned word's byte 0 to valid_o/data_o.
- locked_o and offset_o are registered and asserted the cycle after the state change.
- Reset asserted mid-stream: everything returns to reset values immediately; no partial word is emitted after reset release.
- Saturation: good_cnt and bad_cnt are 4 bits and never wrap, because the thresholds are at most 15.

Optional Feature:
GTX_RX_ERR_CNT_EN
- Defined: adds output err_cnt_o [15:0], which counts every error cycle while LOCKED. It saturates at 16'hFFFF and is cleared only by reset.
- Undefined: the port and counter are absent.

Decomposition:
- Shared package gtx_pkg, used by both gtx_tx and gtx_rx:
  - K28_5 = 8'hBC.
  - IDLE_WORD = 16'h50BC, with IDLE_CTRL = 2'b01.
  - Enum rx_state_t {HUNT, CHECK, LOCKED}.
- One sub-module, gtx_rx_align, contains the stage-1 registers, the offset mux and raw comma detection.
- The FSM and output stage stay in gtx_rx.

Test Plan:
- Aligned stream: 3x IDLE_WORD/ctrl=01 then 16'hDEAD/ctrl=00 -> locked_o rises after the 3rd comma, offset_o=0, data_o=16'hDEAD with valid_o=1, 2 cycles after input.
- Misaligned stream: words 16'hBCxx/ctrl=10 and 16'hAD50 for DEAD payload split across words -> offset_o=1, output 16'hDEAD, valid_o=1.
- Loss of lock: LOCKED, then 4 words with codeerr_i=2'b01 and no comma -> locked_o=0 one cycle after the 4th error, valid_o=0 from then on.
- Error recovery: 3 errors, then a good comma, then 3 errors -> stays LOCKED.
- Error in CHECK: 1 comma then an error -> back to HUNT, no valid_o ever asserted.
- Reset mid-stream: rst_n_i low for 1 cycle while streaming DEAD -> all outputs 0 and state HUNT; lock is reacquired after 3 commas.
- GTX_RX_ERR_CNT_EN defined, 5 errors while LOCKED -> err_cnt_o=4; the 5th error falls after lock loss and is not counted.
